// File: rtl/pipeline_stall_controller_pkg.sv
// Shared types and constants for the pipeline stall controller.
// Holds the FSM state encoding, the default SRAM latency and the NOP control word.
package pipeline_stall_controller_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int DEFAULT_MEM_LATENCY = 6;

    localparam int CTRL_W = 8;
    localparam logic [CTRL_W-1:0] NOP_CTRL = '0;

    // Pipeline registers use this when deciding whether a control word is a bubble.
    function automatic logic is_nop(input logic [CTRL_W-1:0] ctrl);
        return ctrl == NOP_CTRL;
    endfunction

endpackage

// File: rtl/pipeline_stall_controller_wait_counter.sv
// Access cycle counter: clear, load-to-one and increment, with a terminal
// count flag raised on the last frozen cycle of an SRAM access.
module access_wait_counter #(
    parameter int CNT_W       = 3,
    parameter int MEM_LATENCY = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             load,
    input  logic             enable,
    output logic [CNT_W-1:0] cnt,
    output logic             tc
);

    localparam logic [CNT_W-1:0] TC_VAL = CNT_W'(MEM_LATENCY - 1);

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= CNT_W'(1);
        end else if (enable) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    assign tc = (cnt == TC_VAL);

endmodule

// File: rtl/pipeline_stall_controller.sv
// Freeze/flush/bubble sequencer for the 5-stage pipeline; stretches each
// MEM-stage load/store over MEM_LATENCY frozen cycles plus one release cycle.
//
// state | meaning
// IDLE  | no access running; a MEM request freezes the pipe and starts one
// WAIT  | SRAM access in progress, whole pipeline frozen
// DONE  | access finished, MEM instruction advances; hazard/branch logic live
module pipeline_stall_controller
    import pipeline_stall_controller_pkg::*;
#(
    parameter int MEM_LATENCY = DEFAULT_MEM_LATENCY,
    parameter int CNT_W       = 3,
    parameter int STAT_W      = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              hazard_detected,
    input  logic              br_taken,
    input  logic              mem_r_en,
    input  logic              mem_w_en,
    output logic              pc_freeze,
    output logic              if_id_freeze,
    output logic              if_id_flush,
    output logic              id_exe_freeze,
    output logic              id_exe_bubble,
    output logic              exe_mem_freeze,
    output logic              mem_wb_bubble,
    output logic              mem_busy,
    output logic [STAT_W-1:0] stall_count
);

    state_t           state;
    state_t           state_nxt;
    logic             mem_req;
    logic [CNT_W-1:0] cnt;
    logic             cnt_tc;
    logic             mem_freeze;

    assign mem_req = mem_r_en | mem_w_en;

    access_wait_counter #(
        .CNT_W       (CNT_W),
        .MEM_LATENCY (MEM_LATENCY)
    ) u_wait_cnt (
        .clk    (clk),
        .rst    (rst),
        .clear  (state == WAIT && cnt_tc),
        .load   (state == IDLE && mem_req),
        .enable (state == WAIT),
        .cnt    (cnt),
        .tc     (cnt_tc)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = IDLE;
        case (state)
            IDLE:    state_nxt = mem_req ? WAIT : IDLE;
            WAIT:    state_nxt = cnt_tc ? DONE : WAIT;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Memory freeze wins; hazard/branch only act once MEM is not holding the pipe.
    always_comb begin
        mem_freeze     = 1'b0;
        pc_freeze      = 1'b0;
        if_id_freeze   = 1'b0;
        if_id_flush    = 1'b0;
        id_exe_freeze  = 1'b0;
        id_exe_bubble  = 1'b0;
        exe_mem_freeze = 1'b0;
        mem_wb_bubble  = 1'b0;
        mem_busy       = 1'b0;
        if (!rst) begin
            mem_freeze = (state == WAIT) || (state == IDLE && mem_req);
            if (mem_freeze) begin
                pc_freeze      = 1'b1;
                if_id_freeze   = 1'b1;
                id_exe_freeze  = 1'b1;
                exe_mem_freeze = 1'b1;
                mem_wb_bubble  = 1'b1;
                mem_busy       = 1'b1;
            end else if (hazard_detected) begin
                pc_freeze     = 1'b1;
                if_id_freeze  = 1'b1;
                id_exe_bubble = 1'b1;
            end else if (br_taken) begin
                if_id_flush = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_count <= '0;
        end else if (pc_freeze && stall_count != {STAT_W{1'b1}}) begin
            stall_count <= stall_count + STAT_W'(1);
        end
    end

endmodule

// File: doc/pipeline_stall_controller.md
Name: pipeline_stall_controller

Overview:
Central freeze/flush/bubble sequencer for the 5-stage MIPS pipeline. It combines the ID-stage hazard indication, the ID-stage branch decision and the MEM-stage memory request into per-register control strobes. It also stretches every MEM-stage load or store over a fixed multi-cycle SRAM access, freezing the whole pipeline while the access runs. It sits beside the pipeline registers and drives the PC, IF/ID, ID/EXE, EXE/MEM and MEM/WB control inputs.

Parameters:
MEM_LATENCY, 6, total SRAM access cycles per load/store, counting the request cycle; legal range 2..2**CNT_W-1.
CNT_W, 3, width of the access cycle counter.
STAT_W, 16, width of the stall statistics counter.

Ports:
clk  input  1  pipeline clock; all state updates on rising edge
rst  input  1  synchronous, active-high reset
hazard_detected  input  1  RAW hazard from the hazard unit for the instruction in ID
br_taken  input  1  branch taken, resolved in ID
mem_r_en  input  1  MEM-stage instruction is a load
mem_w_en  input  1  MEM-stage instruction is a store
pc_freeze  output  1  hold PC
if_id_freeze  output  1  hold IF/ID register
if_id_flush  output  1  clear IF/ID register (squash fetched instruction)
id_exe_freeze  output  1  hold ID/EXE register
id_exe_bubble  output  1  load NOP controls into ID/EXE
exe_mem_freeze  output  1  hold EXE/MEM register
mem_wb_bubble  output  1  load NOP controls into MEM/WB
mem_busy  output  1  SRAM access in progress (state WAIT, or IDLE with a request)
stall_count  output  STAT_W  cycles with pc_freeze=1 since reset, saturating

Behaviour:
- mem_req = mem_r_en | mem_w_en.
- FSM states: IDLE, WAIT, DONE.
- Reset: state=IDLE, cnt=0, stall_count=0.
- While rst=1, all strobe outputs and mem_busy are forced to 0.
- Outputs are combinational from the state and current inputs. There is no output register, so freeze takes effect in the same cycle the request is seen.
- IDLE, mem_req=1 (memory freeze):
  - pc_freeze, if_id_freeze, id_exe_freeze, exe_mem_freeze, mem_wb_bubble and mem_busy are all 1.
  - Next state WAIT, cnt<=1.
- WAIT: same outputs as the memory freeze. cnt increments each cycle; when cnt==MEM_LATENCY-1, next state DONE and cnt<=0.
- DONE:
  - Memory outputs are 0, so the MEM instruction advances at the end of this cycle.
  - mem_req is ignored in this cycle; it is the same instruction still sitting in MEM.
  - Next state IDLE.
- Access timing: request seen at cycle t gives memory freeze at cycles t..t+MEM_LATENCY-1, release at t+MEM_LATENCY. Each load/store costs MEM_LATENCY+1 cycles in MEM.
- Hazard and branch logic applies only in IDLE with mem_req=0, and in DONE. Priority:
  1. Memory freeze. While active, hazard bubbles and branch flushes are suppressed. The ID contents are frozen, so the condition re-evaluates on release and no event is lost.
  2. hazard_detected=1 gives pc_freeze=1, if_id_freeze=1, id_exe_bubble=1. if_id_flush is forced to 0 even if br_taken=1, because branch operands are not yet valid.
  3. br_taken=1 with no hazard gives if_id_flush=1. The PC loads the target through the existing path, with no freeze.
- No strobe pair (freeze, flush/bubble) on the same register is ever asserted together.
- stall_count increments on every cycle with pc_freeze=1 and holds at 2**STAT_W-1.
- Back-to-back memory instructions: the DONE→IDLE transition lets the next load/store start a new access the cycle after DONE.
- Reset asserted mid-access: the next state is IDLE immediately, the access is abandoned and the pipeline registers are reset by the same rst.

Decomposition:
- Shared package/include holds:
  - state encodings IDLE=2'd0, WAIT=2'd1, DONE=2'd2;
  - default MEM_LATENCY;
  - NOP control-word constant used by the bubble inputs.
- One sub-module, access_wait_counter: loadable up-counter (clear, enable, terminal-count output at MEM_LATENCY-1). The FSM and priority mux stay in the top module.

Test Plan:
- Reset: assert rst for 2 cycles with mem_r_en=1, hazard_detected=1 → all outputs 0, stall_count=0; state IDLE after release.
- Single hazard: hazard_detected=1 for one cycle in IDLE → pc_freeze=if_id_freeze=id_exe_bubble=1 that cycle only; stall_count=1.
- Hazard+branch same cycle: hazard_detected=1, br_taken=1 → if_id_flush=0, bubble=1. Next cycle with hazard=0, br_taken=1 → if_id_flush=1.
- Load, MEM_LATENCY=6: mem_r_en=1 from cycle 10 → freeze/mem_busy=1 at cycles 10–15, 0 at cycle 16 (DONE), IDLE at 17; stall_count=6. A br_taken during 12–14 produces no flush until cycle 16.
- Back-to-back store then load: request at 10, next instruction's request from 17 → second freeze at 17–22, release 23; stall_count=12.
- Reset mid-access: rst at cycle 13 of an access → outputs 0 in cycle 13, IDLE at 14; stall_count=0. Saturation with STAT_W=4: 20 frozen cycles → stall_count=15.
